// File: rtl/decision_unit.sv
// Decision responder: finds the lowest-index unassigned variable, raises the decision level and
// issues one assignment per request. Define DECISION_PHASE_SAVE_EN to decide with saved phases.
module decision_unit #(
    parameter int unsigned NUM_VARS      = 8,
    parameter int unsigned WIDTH_VAR_IDX = 3,
    parameter int unsigned NUM_CLAUSES   = 8,
    parameter int unsigned WIDTH_LVL     = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start_decision_i,
    output logic                     done_decision_o,
    input  logic [2*NUM_VARS-1:0]    var_state_i,
    input  logic [NUM_CLAUSES-1:0]   clause_sat_i,
    output logic                     all_c_is_sat_o,
    output logic [WIDTH_LVL-1:0]     cur_lvl_o,
    input  logic                     bkt_lvl_valid_i,
    input  logic [WIDTH_LVL-1:0]     bkt_lvl_i,
    output logic                     assign_valid_o,
    output logic [WIDTH_VAR_IDX-1:0] assign_var_o,
    output logic                     assign_value_o,
    output logic [WIDTH_LVL-1:0]     assign_lvl_o,
    output logic                     no_free_var_o,
    output logic                     lvl_ovf_o
);

    typedef enum logic [1:0] {StIdle, StScan, StAssign, StDone} state_e;

    state_e                   state_q;
    logic [WIDTH_VAR_IDX-1:0] ptr_q;
    logic [WIDTH_VAR_IDX-1:0] idx_q;
    logic [WIDTH_LVL-1:0]     cur_lvl_q;
    logic [1:0]               ptr_state;
    logic                     ptr_last;
    logic                     lvl_max;
    logic [WIDTH_LVL-1:0]     lvl_next;
    logic                     assign_active;
    logic                     phase_bit;

    always_comb begin
        ptr_state = 2'b00;
        for (int unsigned k = 0; k < NUM_VARS; k++) begin
            if (ptr_q == WIDTH_VAR_IDX'(k)) begin
                ptr_state = var_state_i[2*k +: 2];
            end
        end
    end

    assign ptr_last = (ptr_q == WIDTH_VAR_IDX'(NUM_VARS - 1));
    assign lvl_max  = &cur_lvl_q;
    assign lvl_next = lvl_max ? cur_lvl_q : cur_lvl_q + WIDTH_LVL'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= StIdle;
            ptr_q           <= '0;
            idx_q           <= '0;
            cur_lvl_q       <= '0;
            done_decision_o <= 1'b0;
            no_free_var_o   <= 1'b0;
            lvl_ovf_o       <= 1'b0;
        end else begin
            done_decision_o <= 1'b0;
            // Backtrack load wins over the ASSIGN increment below.
            if (bkt_lvl_valid_i) begin
                cur_lvl_q <= bkt_lvl_i;
            end
            unique case (state_q)
                StIdle: begin
                    if (start_decision_i) begin
                        state_q       <= StScan;
                        ptr_q         <= '0;
                        no_free_var_o <= 1'b0;
                    end
                end
                StScan: begin
                    if (bkt_lvl_valid_i) begin
                        state_q <= StIdle;
                    end else if (ptr_state == 2'b00) begin
                        idx_q   <= ptr_q;
                        state_q <= StAssign;
                    end else if (ptr_last) begin
                        state_q         <= StDone;
                        no_free_var_o   <= 1'b1;
                        done_decision_o <= 1'b1;
                    end else begin
                        ptr_q <= ptr_q + WIDTH_VAR_IDX'(1);
                    end
                end
                StAssign: begin
                    if (bkt_lvl_valid_i) begin
                        state_q <= StIdle;
                    end else begin
                        if (lvl_max) begin
                            lvl_ovf_o <= 1'b1;
                        end else begin
                            cur_lvl_q <= lvl_next;
                        end
                        state_q         <= StDone;
                        done_decision_o <= 1'b1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            all_c_is_sat_o <= 1'b0;
        end else begin
            all_c_is_sat_o <= &clause_sat_i;
        end
    end

`ifdef DECISION_PHASE_SAVE_EN
    logic [NUM_VARS-1:0] phase_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase_q <= '0;
        end else begin
            for (int unsigned k = 0; k < NUM_VARS; k++) begin
                if (var_state_i[2*k +: 2] == 2'b01 || var_state_i[2*k +: 2] == 2'b10) begin
                    phase_q[k] <= var_state_i[2*k+1];
                end
            end
        end
    end

    always_comb begin
        phase_bit = 1'b0;
        for (int unsigned k = 0; k < NUM_VARS; k++) begin
            if (idx_q == WIDTH_VAR_IDX'(k)) begin
                phase_bit = phase_q[k];
            end
        end
    end
`else
    assign phase_bit = 1'b0;
`endif

    // The pulse is suppressed in the cycle a backtrack aborts the assignment.
    assign assign_active  = (state_q == StAssign) && !bkt_lvl_valid_i;
    assign assign_valid_o = assign_active;
    assign assign_var_o   = assign_active ? idx_q : '0;
    assign assign_lvl_o   = assign_active ? lvl_next : '0;
    assign assign_value_o = assign_active & phase_bit;
    assign cur_lvl_o      = cur_lvl_q;

endmodule

// File: tb/tb_decision_unit.sv
// Self-checking bench for decision_unit: vector table, directed corner sequences and random
// decisions against a reference model; honours DECISION_PHASE_SAVE_EN.
module tb_decision_unit;

    localparam int NV = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, start2;
    logic [15:0] var_state;
    logic [7:0]  clause_sat;
    logic        bkt_valid, bkt_valid2;
    logic [15:0] bkt_lvl;
    logic [1:0]  bkt_lvl2;

    logic        done, all_sat, assign_valid, assign_value, no_free, lvl_ovf;
    logic [15:0] cur_lvl, assign_lvl;
    logic [2:0]  assign_var;
    logic        done2, all_sat2, assign_valid2, assign_value2, no_free2, lvl_ovf2;
    logic [1:0]  cur_lvl2, assign_lvl2;
    logic [2:0]  assign_var2;

    decision_unit dut (
        .clk(clk), .rst(rst), .start_decision_i(start), .done_decision_o(done),
        .var_state_i(var_state), .clause_sat_i(clause_sat), .all_c_is_sat_o(all_sat),
        .cur_lvl_o(cur_lvl), .bkt_lvl_valid_i(bkt_valid), .bkt_lvl_i(bkt_lvl),
        .assign_valid_o(assign_valid), .assign_var_o(assign_var),
        .assign_value_o(assign_value), .assign_lvl_o(assign_lvl),
        .no_free_var_o(no_free), .lvl_ovf_o(lvl_ovf)
    );

    decision_unit #(.WIDTH_LVL(2)) dut2 (
        .clk(clk), .rst(rst), .start_decision_i(start2), .done_decision_o(done2),
        .var_state_i(var_state), .clause_sat_i(clause_sat), .all_c_is_sat_o(all_sat2),
        .cur_lvl_o(cur_lvl2), .bkt_lvl_valid_i(bkt_valid2), .bkt_lvl_i(bkt_lvl2),
        .assign_valid_o(assign_valid2), .assign_var_o(assign_var2),
        .assign_value_o(assign_value2), .assign_lvl_o(assign_lvl2),
        .no_free_var_o(no_free2), .lvl_ovf_o(lvl_ovf2)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Reference model state
    logic [15:0]   vs_m;
    logic [NV-1:0] saved_m;
    logic [15:0]   model_lvl;
    bit            model_ovf;

    typedef struct {
        logic [15:0] vs;
        logic [7:0]  cs;
        int          bkt_mode;  // 0 none, 1 load in the cycle before start, 2 with start
        logic [15:0] bkt_v;
        int          exp_k;     // NV means no free variable
        logic [15:0] exp_lvl;
    } vec_t;

    vec_t tbl[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic int first_free(input logic [15:0] v);
        for (int j = 0; j < NV; j++) begin
            if (v[2*j +: 2] == 2'b00) return j;
        end
        return NV;
    endfunction

    task automatic apply_vs(input logic [15:0] v);
        var_state = v;
        vs_m = v;
        for (int j = 0; j < NV; j++) begin
            if (v[2*j +: 2] == 2'b01) saved_m[j] = 1'b0;
            if (v[2*j +: 2] == 2'b10) saved_m[j] = 1'b1;
        end
    endtask

    task automatic bkt_load(input logic [15:0] v);
        bkt_valid = 1'b1;
        bkt_lvl = v;
        cyc();
        bkt_valid = 1'b0;
        model_lvl = v;
    endtask

    // Start pulse in the current cycle; checks every cycle through one idle cycle after done.
    task automatic run_decision(input int k, input logic [15:0] exp_lvl, input bit exp_ovf,
                                input bit bkt_same, input logic [15:0] bkt_v, input int extra_c);
        int  limit;
        bit  exp_val;
        limit = (k < NV) ? k + 3 : NV + 1;
`ifdef DECISION_PHASE_SAVE_EN
        exp_val = (k < NV) ? saved_m[k] : 1'b0;
`else
        exp_val = 1'b0;
`endif
        start = 1'b1;
        bkt_valid = bkt_same;
        bkt_lvl = bkt_v;
        for (int c = 1; c <= limit + 1; c++) begin
            cyc();
            start = (c == extra_c);
            bkt_valid = 1'b0;
            #2;
            check("assign_valid", 32'(assign_valid), 32'(k < NV && c == k + 2));
            check("done_pulse", 32'(done), 32'(c == limit));
            if (k < NV && c == k + 2) begin
                check("assign_var", 32'(assign_var), 32'(k));
                check("assign_lvl", 32'(assign_lvl), 32'(exp_lvl));
                check("assign_value", 32'(assign_value), 32'(exp_val));
            end
            if (c == limit) begin
                check("cur_lvl", 32'(cur_lvl), 32'(exp_lvl));
                check("no_free_var", 32'(no_free), 32'(k == NV));
                check("lvl_ovf", 32'(lvl_ovf), 32'(exp_ovf));
                check("all_c_is_sat", 32'(all_sat), 32'(&clause_sat));
            end
        end
        start = 1'b0;
        model_lvl = exp_lvl;
        model_ovf = exp_ovf;
    endtask

    initial begin
        bit seen;
        rst = 1'b0;
        start = 1'b0;
        start2 = 1'b0;
        bkt_valid = 1'b0;
        bkt_valid2 = 1'b0;
        bkt_lvl = '0;
        bkt_lvl2 = '0;
        var_state = '0;
        clause_sat = '0;
        vs_m = '0;
        saved_m = '0;
        model_lvl = '0;
        model_ovf = 1'b0;

        tbl[0] = '{vs: 16'h0000, cs: 8'h00, bkt_mode: 0, bkt_v: 16'd0,  exp_k: 0,  exp_lvl: 16'd1};
        tbl[1] = '{vs: 16'h02AA, cs: 8'h7F, bkt_mode: 1, bkt_v: 16'd3,  exp_k: 5,  exp_lvl: 16'd4};
        tbl[2] = '{vs: 16'h5555, cs: 8'hFF, bkt_mode: 0, bkt_v: 16'd0,  exp_k: NV, exp_lvl: 16'd4};
        tbl[3] = '{vs: 16'h5515, cs: 8'hFF, bkt_mode: 2, bkt_v: 16'd10, exp_k: 3,  exp_lvl: 16'd11};
        tbl[4] = '{vs: 16'h3FFF, cs: 8'hFE, bkt_mode: 0, bkt_v: 16'd0,  exp_k: 7,  exp_lvl: 16'd12};

        // Reset values
        #12;
        check("rst_cur_lvl", 32'(cur_lvl), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_assign_valid", 32'(assign_valid), 32'd0);
        check("rst_assign_lvl", 32'(assign_lvl), 32'd0);
        check("rst_no_free", 32'(no_free), 32'd0);
        check("rst_ovf", 32'(lvl_ovf), 32'd0);
        check("rst_all_sat", 32'(all_sat), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        cyc();

        // Vector table
        for (int i = 0; i < 5; i++) begin
            apply_vs(tbl[i].vs);
            clause_sat = tbl[i].cs;
            if (tbl[i].bkt_mode == 1) bkt_load(tbl[i].bkt_v);
            run_decision(tbl[i].exp_k, tbl[i].exp_lvl, 1'b0, tbl[i].bkt_mode == 2,
                         tbl[i].bkt_v, 0);
        end

        // Phase: var 2 seen true, then unassigned
        apply_vs(16'h5565);
        cyc();
        apply_vs(16'h5545);
        run_decision(2, model_lvl + 16'd1, model_ovf, 1'b0, 16'd0, 0);

        // Backtrack during SCAN aborts with no pulses
        apply_vs(16'h02AA);
        start = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
        bkt_valid = 1'b1;
        bkt_lvl = 16'd2;
        cyc();
        bkt_valid = 1'b0;
        model_lvl = 16'd2;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #2;
            if (assign_valid || done) seen = 1'b1;
            cyc();
        end
        check("abort_scan_no_pulse", 32'(seen), 32'd0);
        check("abort_scan_lvl", 32'(cur_lvl), 32'd2);
        run_decision(5, 16'd3, model_ovf, 1'b0, 16'd0, 0);

        // Backtrack in ASSIGN takes priority over the increment
        apply_vs(16'h0000);
        start = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
        bkt_valid = 1'b1;
        bkt_lvl = 16'd7;
        #2;
        check("abort_assign_gate", 32'(assign_valid), 32'd0);
        cyc();
        bkt_valid = 1'b0;
        model_lvl = 16'd7;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            #2;
            if (assign_valid || done) seen = 1'b1;
            cyc();
        end
        check("abort_assign_no_pulse", 32'(seen), 32'd0);
        check("abort_assign_lvl", 32'(cur_lvl), 32'd7);

        // Random decisions against the model
        for (int it = 0; it < 60; it++) begin
            int          k, kk, mode, ec, lim;
            logic [15:0] v, bv, lvl;
            logic [1:0]  s;
            bit          ovf;
            k = $urandom_range(0, NV);
            v = '0;
            for (int j = 0; j < NV; j++) begin
                if (j < k) s = 2'($urandom_range(1, 3));
                else if (j == k) s = 2'b00;
                else s = 2'($urandom_range(0, 3));
                v[2*j +: 2] = s;
            end
            apply_vs(v);
            clause_sat = ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom);
            mode = $urandom_range(0, 2);
            bv = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
            if (mode == 1) bkt_load(bv);
            kk = first_free(vs_m);
            lvl = (mode == 2) ? bv : model_lvl;
            ovf = model_ovf;
            if (kk < NV) begin
                if (lvl == 16'hFFFF) ovf = 1'b1;
                else lvl = lvl + 16'd1;
            end
            lim = (kk < NV) ? kk + 3 : NV + 1;
            ec = ($urandom_range(0, 2) == 0) ? int'($urandom_range(2, lim)) : 0;
            run_decision(kk, lvl, ovf, mode == 2, bv, ec);
        end

        // Level overflow on a 2-bit level instance
        apply_vs(16'h0000);
        bkt_valid2 = 1'b1;
        bkt_lvl2 = 2'd2;
        cyc();
        bkt_valid2 = 1'b0;
        for (int r = 0; r < 2; r++) begin
            start2 = 1'b1;
            cyc();
            start2 = 1'b0;
            cyc();
            #2;
            check("ovf_assign_valid", 32'(assign_valid2), 32'd1);
            check("ovf_assign_lvl", 32'(assign_lvl2), 32'd3);
            check("ovf_assign_var", 32'(assign_var2), 32'd0);
            cyc();
            #2;
            check("ovf_done", 32'(done2), 32'd1);
            check("ovf_flag", 32'(lvl_ovf2), 32'(r == 1));
            check("ovf_cur_lvl", 32'(cur_lvl2), 32'd3);
            check("ovf_no_free", 32'(no_free2), 32'd0);
            cyc();
        end
        bkt_valid2 = 1'b1;
        bkt_lvl2 = 2'd1;
        cyc();
        bkt_valid2 = 1'b0;
        #2;
        check("ovf_sticky_after_bkt", 32'(lvl_ovf2), 32'd1);
        check("ovf_bkt_lvl", 32'(cur_lvl2), 32'd1);

        // Asynchronous reset in the middle of a scan
        apply_vs(16'h5555);
        start = 1'b1;
        start2 = 1'b1;
        cyc();
        start = 1'b0;
        start2 = 1'b0;
        cyc();
        cyc();
        #2;
        rst = 1'b0;
        #1;
        check("midrst_cur_lvl", 32'(cur_lvl), 32'd0);
        check("midrst_cur_lvl2", 32'(cur_lvl2), 32'd0);
        check("midrst_ovf2", 32'(lvl_ovf2), 32'd0);
        check("midrst_no_free", 32'(no_free), 32'd0);
        check("midrst_ovf", 32'(lvl_ovf), 32'd0);
        saved_m = '0;
        model_lvl = '0;
        model_ovf = 1'b0;
        cyc();
        cyc();
        @(negedge clk);
        rst = 1'b1;
        apply_vs(16'h5555);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            cyc();
            #2;
            if (done || done2 || assign_valid) seen = 1'b1;
        end
        check("midrst_no_done", 32'(seen), 32'd0);
        apply_vs(16'h0000);
        run_decision(0, 16'd1, 1'b0, 1'b0, 16'd0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/decision_unit.md
Name: decision_unit

Overview:
- Responder for the decision handshake in the sat engine.
- On a `start_decision_i` pulse, scans the current bin's variable states for the lowest-index unassigned variable, raises the decision level, issues one assignment, then pulses `done_decision_o`.
- Also supplies `cur_lvl_o` and `all_c_is_sat_o` to the core controller.
- Sits between the core controller and the variable/clause arrays.

Parameters:
- NUM_VARS, 8, number of variables held in one bin
- WIDTH_VAR_IDX, 3, width of a variable index; 2**WIDTH_VAR_IDX >= NUM_VARS
- NUM_CLAUSES, 8, number of clauses held in one bin
- WIDTH_LVL, 16, width of a decision level

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-low (0 = reset)
- start_decision_i  in  1  one-cycle request pulse from the core controller
- done_decision_o  out  1  one-cycle completion pulse
- var_state_i  in  2*NUM_VARS  per-var state, var k at [2k+1:2k]; 00 unassigned, 01 false, 10 true, 11 treated as assigned
- clause_sat_i  in  NUM_CLAUSES  per-clause satisfied flag
- all_c_is_sat_o  out  1  registered AND of clause_sat_i
- cur_lvl_o  out  WIDTH_LVL  current decision level
- bkt_lvl_valid_i  in  1  load cur_lvl from bkt_lvl_i this cycle
- bkt_lvl_i  in  WIDTH_LVL  backtrack target level
- assign_valid_o  out  1  one-cycle pulse: write decision into var array
- assign_var_o  out  WIDTH_VAR_IDX  decided variable index
- assign_value_o  out  1  decided polarity (1 = true)
- assign_lvl_o  out  WIDTH_LVL  level tagged on the assignment
- no_free_var_o  out  1  held high from done of a failed scan until next start
- lvl_ovf_o  out  1  sticky; set when an increment is blocked at max level

Behaviour:
- Reset values:
  - cur_lvl_o = 0; all outputs 0; FSM in IDLE.
  - Reset is asynchronous and aborts any scan mid-operation with no done pulse.
- all_c_is_sat_o: registered every cycle as &clause_sat_i, independent of FSM state (1-cycle latency).
- FSM states are IDLE, SCAN, ASSIGN, DONE.
- IDLE:
  - On start_decision_i, go to SCAN and clear the scan pointer and no_free_var_o.
  - start_decision_i in any state other than IDLE is ignored.
- SCAN:
  - Examines one var per cycle; the pointer goes 0..NUM_VARS-1.
  - If var_state of var[ptr] == 00, latch ptr and go to ASSIGN.
  - If ptr == NUM_VARS-1 and that var is assigned, go to DONE with no_free_var_o=1; no level change and no assign pulse.
- ASSIGN:
  - Increment cur_lvl_o. If already 2**WIDTH_LVL-1, hold the level and set lvl_ovf_o.
  - In the same cycle pulse assign_valid_o with assign_lvl_o = the new cur_lvl value, assign_var_o = the latched index, and assign_value_o per the phase rule.
  - Next state is DONE.
- DONE:
  - Pulse done_decision_o for exactly one cycle, then go to IDLE.
- Latency: with the start pulse in cycle T and the free var at index k:
  - assign_valid_o is high in cycle T+k+2.
  - done_decision_o is high in cycle T+k+3.
  - If there is no free var, done_decision_o is high in cycle T+NUM_VARS+1.
- Backtrack:
  - bkt_lvl_valid_i in any state loads cur_lvl_o <= bkt_lvl_i next edge.
  - It aborts SCAN/ASSIGN to IDLE with no assign or done pulse.
  - In ASSIGN it takes priority over the increment.
  - It does not clear lvl_ovf_o; only reset clears lvl_ovf_o.
- Simultaneous start_decision_i and bkt_lvl_valid_i in IDLE: both accepted; the level load occurs and the scan starts, so a later increment builds on bkt_lvl_i.
- var_state_i is sampled live during SCAN; the engine holds it stable while a decision is in flight.
- Default phase: assign_value_o = 0 (decide false).

Optional Feature:
- Macro: DECISION_PHASE_SAVE_EN.
- When defined:
  - A NUM_VARS-bit saved-phase register is reset to 0.
  - Every cycle, for each var whose state is 01 or 10, the register records bit = (state==10).
  - assign_value_o = the saved bit of the decided var.
- When undefined: there is no register and assign_value_o is always 0.

Test Plan:
- Free var at 0: after reset, var_state all 00, start pulse at T -> assign_valid at T+2 with var=0, value=0, lvl=1; done at T+3; cur_lvl=1.
- Free var at 5: vars 0-4 = 10, vars 5-7 = 00, cur_lvl=3, start -> assign var=5, lvl=4 at T+7; done at T+8.
- All assigned: var_state all 01, start -> no assign pulse; done at T+9 (NUM_VARS=8); no_free_var_o=1; cur_lvl unchanged. With clause_sat_i=8'hFF, all_c_is_sat_o=1 in the done cycle.
- Backtrack abort: start, then bkt_lvl_valid=1 with bkt_lvl=2 during SCAN -> no assign, no done, cur_lvl=2; a following start decides at lvl 3.
- Overflow: WIDTH_LVL=2, cur_lvl=3, start with a free var -> assign_lvl=3, lvl_ovf_o=1, done still pulses; asserting rst low mid-scan clears everything immediately.
- With DECISION_PHASE_SAVE_EN: var 2 seen as 10, then 00, start -> assign var=2, value=1. Without the macro, the same stimulus gives value=0.
